// File: rtl/reveal_engine_pkg.sv
// -----------------------------------------------------------------------------
// reveal_engine_pkg
// Shared board geometry and cell encoding for the minesweeper reveal engine,
// plus small helpers for cell extraction and 8-neighbour offsets.
// The FSM state encoding is kept local to reveal_engine.
// -----------------------------------------------------------------------------
package reveal_engine_pkg;

  // Board geometry and cell encoding
  localparam int MAP_WIDTH       = 16;  // columns
  localparam int MAP_HEIGHT      = 16;  // rows
  localparam int MAP_CELL_LENGTH = 4;   // bits per cell
  localparam int MAP_X_BITS      = 4;   // column index width
  localparam int MAP_Y_BITS      = 4;   // row index width

  localparam logic [MAP_CELL_LENGTH-1:0] IS_MINE = 4'd9;

  // Derived sizes
  localparam int MAP_CELLS    = MAP_WIDTH * MAP_HEIGHT;
  localparam int MAP_BITS     = MAP_CELLS * MAP_CELL_LENGTH;
  localparam int MAP_POS_BITS = $clog2(MAP_CELLS);
  // Must be able to count a full MAP_CELLS passes.
  localparam int PASS_BITS    = $clog2(MAP_CELLS + 1);

  // Value of the cell at linear position pos.
  function automatic logic [MAP_CELL_LENGTH-1:0] cell_at(
    input logic [MAP_BITS-1:0]     map,
    input logic [MAP_POS_BITS-1:0] pos
  );
    return map[int'(pos)*MAP_CELL_LENGTH +: MAP_CELL_LENGTH];
  endfunction

  // Neighbour k (0..7) column offset, in raster order:
  // (-1,-1) (0,-1) (1,-1) (-1,0) (1,0) (-1,1) (0,1) (1,1)
  function automatic int nbr_dx(input int k);
    case (k)
      0, 3, 5: return -1;
      1, 6:    return 0;
      default: return 1;
    endcase
  endfunction

  // Neighbour k (0..7) row offset, same ordering as nbr_dx.
  function automatic int nbr_dy(input int k);
    if (k < 3)      return -1;
    else if (k < 5) return 0;
    else            return 1;
  endfunction

endpackage

// File: rtl/reveal_engine_cell.sv
// -----------------------------------------------------------------------------
// reveal_cell
// Combinational next-shown decision for one board cell during flood fill.
// A cell is revealed this pass when it is hidden, unflagged, not a mine and
// touches at least one shown zero-valued in-map neighbour.
// Ports:
//   value    - this cell's encoded value (0..8 or IS_MINE)
//   flag     - this cell is flagged
//   shown    - this cell is already shown
//   nbr_zero - per neighbour: shown and zero (out-of-map neighbours tied 0)
//   reveal   - cell becomes shown at the next spread edge
// -----------------------------------------------------------------------------
module reveal_cell
  import reveal_engine_pkg::*;
(
  input  logic [MAP_CELL_LENGTH-1:0] value,
  input  logic                       flag,
  input  logic                       shown,
  input  logic [7:0]                 nbr_zero,
  output logic                       reveal
);

  assign reveal = !shown && !flag && (value != IS_MINE) && (|nbr_zero);

endmodule

// File: rtl/reveal_engine.sv
// -----------------------------------------------------------------------------
// reveal_engine
// Minesweeper reveal engine. A legal click opens one cell; opening a zero
// cell starts a parallel flood fill that reveals every reachable cell one
// Chebyshev ring per clock until the board stops changing.
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   map_i         - packed cell values, cell pos at [pos*4 +: 4]
//   map_flag_i    - per-cell flag, 1 = flagged (sampled live while spreading)
//   click_valid_i - reveal request strobe with click_x_i / click_y_i
//   clear_i       - new game: hide all cells, abort any reveal
//   map_shown_o   - registered per-cell shown bits
//   busy_o        - engine is not idle
//   reveal_done_o - one-cycle pulse when a reveal completes
// -----------------------------------------------------------------------------
module reveal_engine
  import reveal_engine_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MAP_BITS-1:0]     map_i,
  input  logic [MAP_CELLS-1:0]    map_flag_i,
  input  logic                    click_valid_i,
  input  logic [MAP_X_BITS-1:0]   click_x_i,
  input  logic [MAP_Y_BITS-1:0]   click_y_i,
  input  logic                    clear_i,
  output logic [MAP_CELLS-1:0]    map_shown_o,
  output logic                    busy_o,
  output logic                    reveal_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_SPREAD = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [PASS_BITS-1:0] PASS_LAST = PASS_BITS'(MAP_CELLS - 1);

  state_t                  state_q, state_d;
  logic [MAP_CELLS-1:0]    shown_q, shown_d;
  logic [MAP_POS_BITS-1:0] pos_q, pos_d;
  logic [PASS_BITS-1:0]    pass_q, pass_d;

  // ---------------------------------------------------------------------------
  // Click decode
  // ---------------------------------------------------------------------------
  logic                    x_in_map, y_in_map, click_ok;
  logic [MAP_POS_BITS-1:0] click_pos;

  assign x_in_map  = int'(click_x_i) < MAP_WIDTH;
  assign y_in_map  = int'(click_y_i) < MAP_HEIGHT;
  assign click_pos = MAP_POS_BITS'(int'(click_y_i) * MAP_WIDTH + int'(click_x_i));
  assign click_ok  = click_valid_i && x_in_map && y_in_map && !clear_i &&
                     !shown_q[click_pos] && !map_flag_i[click_pos];

  // ---------------------------------------------------------------------------
  // Flood-fill array: one reveal_cell per board position
  // ---------------------------------------------------------------------------
  logic [MAP_CELLS-1:0] shown_zero;
  logic [MAP_CELLS-1:0] reveal;

  for (genvar p = 0; p < MAP_CELLS; p++) begin : g_zero
    assign shown_zero[p] = shown_q[p] &&
                           (map_i[p*MAP_CELL_LENGTH +: MAP_CELL_LENGTH] == '0);
  end

  for (genvar y = 0; y < MAP_HEIGHT; y++) begin : g_row
    for (genvar x = 0; x < MAP_WIDTH; x++) begin : g_col
      logic [7:0] nbr_zero;

      // Neighbours are resolved at elaboration; anything off the board
      // (including what would be a row/column wrap) is a constant 0.
      for (genvar k = 0; k < 8; k++) begin : g_nbr
        localparam int NX = x + nbr_dx(k);
        localparam int NY = y + nbr_dy(k);
        if (NX >= 0 && NX < MAP_WIDTH && NY >= 0 && NY < MAP_HEIGHT) begin : g_in
          assign nbr_zero[k] = shown_zero[NY*MAP_WIDTH + NX];
        end else begin : g_out
          assign nbr_zero[k] = 1'b0;
        end
      end

      reveal_cell u_cell (
        .value    (map_i[(y*MAP_WIDTH + x)*MAP_CELL_LENGTH +: MAP_CELL_LENGTH]),
        .flag     (map_flag_i[y*MAP_WIDTH + x]),
        .shown    (shown_q[y*MAP_WIDTH + x]),
        .nbr_zero (nbr_zero),
        .reveal   (reveal[y*MAP_WIDTH + x])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    shown_d = shown_q;
    pos_d   = pos_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (click_ok) begin
          pos_d   = click_pos;
          state_d = ST_OPEN;
        end
      end

      ST_OPEN: begin
        shown_d[pos_q] = 1'b1;
        pass_d         = '0;
        state_d        = (cell_at(map_i, pos_q) == '0) ? ST_SPREAD : ST_DONE;
      end

      ST_SPREAD: begin
        shown_d = shown_q | reveal;
        pass_d  = pass_q + PASS_BITS'(1);
        // Stop on the first pass that changes nothing; the pass cap is a
        // backstop in case the flag inputs keep moving under the fill.
        if (!(|reveal) || pass_q == PASS_LAST) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new game overrides whatever the engine was doing.
    if (clear_i) begin
      state_d = ST_IDLE;
      shown_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shown_q <= '0;
      pos_q   <= '0;
      pass_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      shown_q <= shown_d;
      pos_q   <= pos_d;
      pass_q  <= pass_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign map_shown_o   = shown_q;
  assign busy_o        = (state_q != ST_IDLE);
  // A clear arriving in DONE cancels the completion pulse.
  assign reveal_done_o = (state_q == ST_DONE) && !clear_i;

endmodule

// File: tb/tb_reveal_engine.sv
// -----------------------------------------------------------------------------
// tb_reveal_engine
// Directed bench for reveal_engine. Stimulus pushes the expected board onto a
// scoreboard; a monitor pops and compares whenever reveal_done_o pulses, and
// flags any pulse nobody asked for. Cycle-level checks (busy, clear, reset,
// ignored clicks) are made inline.
// -----------------------------------------------------------------------------
module tb_reveal_engine;
  import reveal_engine_pkg::*;

  typedef struct {
    string        name;
    logic [255:0] shown;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [MAP_BITS-1:0]  map;
  logic [MAP_CELLS-1:0] flags;
  logic                 click_valid;
  logic [3:0]           click_x;
  logic [3:0]           click_y;
  logic                 clear;
  logic [MAP_CELLS-1:0] shown;
  logic                 busy;
  logic                 done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  reveal_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .map_i         (map),
    .map_flag_i    (flags),
    .click_valid_i (click_valid),
    .click_x_i     (click_x),
    .click_y_i     (click_y),
    .clear_i       (clear),
    .map_shown_o   (shown),
    .busy_o        (busy),
    .reveal_done_o (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, shown, e.shown);
      end
    end
  end

  task automatic set_cell(input int x, input int y, input logic [3:0] v);
    map[(y*16 + x)*4 +: 4] = v;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic click(input int x, input int y);
    click_valid = 1'b1;
    click_x     = 4'(x);
    click_y     = 4'(y);
    @(posedge clk);
    @(negedge clk);
    click_valid = 1'b0;
  endtask

  // Waits (bounded) for the done pulse; cnt=1 is the cycle after acceptance.
  task automatic wait_done(input string name, input int max, output int cnt);
    cnt = 1;
    while (!done && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done within %0d", name, max);
    end
    @(negedge clk);
    check({name, "_idle_after"}, 256'(busy), 256'(0));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_hides_all", 256'(shown), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] e;
    int           cnt;

    // ---------------- reset, with a click held during reset ----------------
    rst_n       = 1'b0;
    map         = '0;
    flags       = '0;
    clear       = 1'b0;
    click_valid = 1'b1;
    click_x     = 4'd0;
    click_y     = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_shown", 256'(shown), 256'(0));
    check("rst_busy",  256'(busy),  256'(0));
    check("rst_done",  256'(done),  256'(0));
    click_valid = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk);
    check("post_rst_shown", 256'(shown), 256'(0));
    check("post_rst_busy",  256'(busy),  256'(0));

    // ---------------- non-zero cell (3,2)=2: single reveal ----------------
    set_cell(3, 2, 4'd2);
    e = '0; e[35] = 1'b1;
    sb_q.push_back('{"open_nonzero", e});
    click(3, 2);
    check("nz_busy_open",  256'(busy),  256'(1));
    check("nz_not_yet",    256'(shown), 256'(0));
    @(negedge clk);
    check("nz_busy_done",  256'(busy),  256'(1));
    check("nz_done_pulse", 256'(done),  256'(1));
    @(negedge clk);
    check("nz_idle",       256'(busy),  256'(0));
    check("nz_done_low",   256'(done),  256'(0));
    do_clear();

    // ---------------- all-zero map: full flood ----------------
    map = '0;
    sb_q.push_back('{"flood_all", {256{1'b1}}});
    click(0, 0);
    wait_done("flood_all", 40, cnt);
    check("flood_within_20", 256'(cnt <= 20), 256'(1));
    do_clear();

    // ---------------- flagged column x=5 blocks the fill ----------------
    for (int y = 0; y < 16; y++) flags[y*16 + 5] = 1'b1;
    e = '0;
    for (int p = 0; p < 256; p++) if ((p % 16) < 5) e[p] = 1'b1;
    sb_q.push_back('{"flag_wall", e});
    click(0, 0);
    wait_done("flag_wall", 40, cnt);
    flags = '0;
    do_clear();

    // ---------------- mine at (7,7): no spread ----------------
    map = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        set_cell(7 + dx, 7 + dy, 4'd1);
    set_cell(7, 7, 4'd9);
    e = '0; e[119] = 1'b1;
    sb_q.push_back('{"open_mine", e});
    click(7, 7);
    wait_done("open_mine", 10, cnt);

    // Re-click on a shown cell and click on a flagged cell are ignored.
    click(7, 7);
    check("reclick_shown_busy", 256'(busy), 256'(0));
    flags[0] = 1'b1;
    click(0, 0);
    check("click_flag_busy", 256'(busy), 256'(0));
    check("ignored_keep_shown", 256'(shown), e);
    flags = '0;
    do_clear();

    // ---------------- clear during the 2nd SPREAD cycle ----------------
    map = '0;
    click(0, 0);
    @(negedge clk);
    e = '0; e[0] = 1'b1;
    check("spread_open_bit", 256'(shown), e);
    @(negedge clk);
    e[1] = 1'b1; e[16] = 1'b1; e[17] = 1'b1;
    check("spread_pass1", 256'(shown), e);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("mid_clear_shown", 256'(shown), 256'(0));
    check("mid_clear_busy",  256'(busy),  256'(0));
    repeat (5) @(negedge clk);
    check("mid_clear_stays_idle", 256'(busy), 256'(0));

    // ---------------- reset in the middle of a spread ----------------
    click(0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_shown", 256'(shown), 256'(0));
    check("async_rst_busy",  256'(busy),  256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_resume_idle",  256'(busy),  256'(0));
    check("rst_resume_shown", 256'(shown), 256'(0));

    // ---------------- wall of 1s at x=1, mine at (0,8): edges, no wrap ----
    map = '0;
    for (int y = 0; y < 16; y++) set_cell(1, y, 4'd1);
    set_cell(0, 8, 4'd9);
    e = '0;
    for (int y = 0; y < 8; y++) e[y*16 + 0] = 1'b1;
    for (int y = 0; y < 9; y++) e[y*16 + 1] = 1'b1;
    sb_q.push_back('{"edge_no_wrap", e});
    click(0, 0);
    wait_done("edge_no_wrap", 40, cnt);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 256'(sb_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
